// File: rtl/store_buffer_dmem_ctrl_if.sv
// Data-memory bus between the store-buffer controller and the backing memory.
// The controller (master) drives a request with direction, word-aligned
// address and write data. The memory (slave) answers with a one-cycle ack and,
// on reads, the read data. All master-driven signals are held stable from
// request until ack.
//   mem_req   : transaction request (master -> slave)
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word-aligned byte address
//   mem_wdata : write data
//   mem_ack   : transaction completes this cycle (slave -> master)
//   mem_rdata : read data, valid with mem_ack on a read
interface store_buffer_dmem_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/store_buffer_dmem_ctrl.sv
// Data-memory controller for a single-cycle core. Stores are posted into a
// DEPTH-entry FIFO and drained to memory in the background; loads that match
// a buffered word are forwarded combinationally from the youngest match;
// loads that miss stall the core until the memory read returns.
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   cpu_memread  : load request            cpu_memwrite : store request
//   cpu_addr     : byte address            cpu_wdata    : store data
//   cpu_rdata    : load data (comb)        cpu_stall    : hold pipeline (comb)
//   dmem         : memory bus (master side), all outputs registered
//   buf_count    : store-buffer occupancy, 0..DEPTH
module store_buffer_dmem_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_memread,
  input  logic                     cpu_memwrite,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [DW-1:0]            cpu_wdata,
  output logic [DW-1:0]            cpu_rdata,
  output logic                     cpu_stall,
  store_buffer_dmem_ctrl_if.master dmem,
  output logic [$clog2(DEPTH):0]   buf_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = AW - 2;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            req_q, req_d, we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [WW-1:0]   buf_addr_q [DEPTH];
  logic [DW-1:0]   buf_data_q [DEPTH];

  logic            hit, load_req, miss, full, push, pop;
  logic [DW-1:0]   hit_data;
  logic            unused_addr_lo;

  // Byte-offset bits never take part in matching or memory addressing.
  assign unused_addr_lo = ^cpu_addr[1:0];

  // Scan from oldest to youngest so the last match seen wins.
  always_comb begin
    logic [PW-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (buf_addr_q[idx] == cpu_addr[AW-1:2])) begin
        hit      = 1'b1;
        hit_data = buf_data_q[idx];
      end
    end
  end

  // A simultaneous read+write is a store; full uses the registered count so a
  // same-cycle pop cannot unblock a store.
  assign load_req  = cpu_memread && !cpu_memwrite;
  assign miss      = load_req && !hit;
  assign full      = (count_q == CW'(DEPTH));
  assign push      = cpu_memwrite && !full;
  assign pop       = (state_q == WRITE) && dmem.mem_ack;
  assign cpu_stall = (cpu_memwrite && full) || (miss && (state_q != RESP));
  assign cpu_rdata = (state_q == RESP)    ? rdata_q  :
                     (load_req && hit)    ? hit_data : '0;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (miss) begin
          state_d = READ;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = {cpu_addr[AW-1:2], 2'b00};
        end else if (count_q != '0) begin
          state_d = WRITE;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = {buf_addr_q[head_q], 2'b00};
          wdata_d = buf_data_q[head_q];
        end
      end
      WRITE: begin
        if (dmem.mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      READ: begin
        if (dmem.mem_ack) begin
          state_d = RESP;
          req_d   = 1'b0;
          rdata_d = dmem.mem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign head_d  = pop  ? head_q + 1'b1 : head_q;
  assign tail_d  = push ? tail_q + 1'b1 : tail_q;
  assign count_d = count_q + CW'(push) - CW'(pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; an entry is only ever read
  // when its slot lies inside the head..count window, which reset empties.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr_q[tail_q] <= cpu_addr[AW-1:2];
      buf_data_q[tail_q] <= cpu_wdata;
    end
  end

  assign dmem.mem_req   = req_q;
  assign dmem.mem_we    = we_q;
  assign dmem.mem_addr  = addr_q;
  assign dmem.mem_wdata = wdata_q;
  assign buf_count      = count_q;
endmodule

// File: tb/tb_store_buffer_dmem_ctrl.sv
// Self-checking bench for store_buffer_dmem_ctrl. A behavioural memory answers
// the bus with configurable ack delays and logs every completed transaction.
// The reference is architectural: program-order store list and a word-indexed
// memory image; loads must return the program-order value of their word and
// memory must see all stores in program order.
module tb_store_buffer_dmem_ctrl;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          cpu_memread, cpu_memwrite;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic [CW-1:0] buf_count;

  store_buffer_dmem_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  store_buffer_dmem_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_memread  (cpu_memread),
    .cpu_memwrite (cpu_memwrite),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .dmem         (bus),
    .buf_count    (buf_count)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        txn_log [$];
  txn_t        exp_wr  [$];
  logic [31:0] mem_arr  [bit [29:0]];
  logic [31:0] ref_arch [bit [29:0]];

  int n_checks = 0;
  int n_errors = 0;
  int ack_mode = 0;      // 0 never, 1 random delay, 2 fixed delay, 3 ack once
  int fixed_delay = 0;
  int wait_cnt = 0;
  int target = 0;
  bit saw_read = 0;

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  function automatic logic [31:0] init_val(input bit [29:0] w);
    return {2'b10, w} ^ 32'h3C5A_9600;
  endfunction

  function logic [31:0] mem_get(input bit [29:0] w);
    return mem_arr.exists(w) ? mem_arr[w] : init_val(w);
  endfunction

  function logic [31:0] arch_get(input bit [29:0] w);
    return ref_arch.exists(w) ? ref_arch[w] : init_val(w);
  endfunction

  task automatic set_mode(input int m);
    ack_mode = m;
    wait_cnt = 0;
    target   = (m == 1) ? int'($urandom_range(0, 3)) : (m == 2) ? fixed_delay : 0;
  endtask

  // Behavioural memory: drives ack/rdata away from the rising edge.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (rst && bus.mem_req) begin
        if (!bus.mem_we) saw_read = 1'b1;
        if (ack_mode != 0) begin
          if (wait_cnt >= target) begin
            bus.mem_ack = 1'b1;
            txn_log.push_back({bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 32'h0});
            if (bus.mem_we) mem_arr[bus.mem_addr[31:2]] = bus.mem_wdata;
            else            bus.mem_rdata = mem_get(bus.mem_addr[31:2]);
            wait_cnt = 0;
            if (ack_mode == 3) ack_mode = 0;
            target = (ack_mode == 1) ? int'($urandom_range(0, 3)) :
                     (ack_mode == 2) ? fixed_delay : 0;
          end else begin
            wait_cnt++;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // One core access: hold request until a non-stalled cycle, then release
  // after the accepting edge. Returns load data and number of stall cycles.
  task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdata,
                        output int stalls);
    bit done = 0;
    cpu_memread  = rd;
    cpu_memwrite = wr;
    cpu_addr     = a;
    cpu_wdata    = d;
    stalls       = 0;
    rdata        = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        done  = 1;
        rdata = cpu_rdata;
        break;
      end
      stalls++;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL op_timeout addr=%h: still stalled after %0d cycles, required release", a, stalls);
    end
    @(posedge clk);
    #1;
    if (done && wr) begin
      exp_wr.push_back({1'b1, a[31:2], 2'b00, d});
      ref_arch[a[31:2]] = d;
    end
    cpu_memread  = 1'b0;
    cpu_memwrite = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (buf_count == '0 && !bus.mem_req) begin
        done = 1;
        break;
      end
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL drain_timeout: buf_count=%0d mem_req=%b, required 0/0", buf_count, bus.mem_req);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input string name);
    txn_t got [$];
    foreach (txn_log[i]) if (txn_log[i].we) got.push_back(txn_log[i]);
    n_checks++;
    if (got.size() != exp_wr.size()) begin
      n_errors++;
      $display("FAIL %s_write_count: got %0d writes, required %0d", name, got.size(), exp_wr.size());
    end
    for (int i = 0; i < got.size() && i < exp_wr.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_wr[i]) begin
        n_errors++;
        $display("FAIL %s_write[%0d]: got addr=%h data=%h, required addr=%h data=%h",
                 name, i, got[i].addr, got[i].data, exp_wr[i].addr, exp_wr[i].data);
      end
    end
    txn_log.delete();
    exp_wr.delete();
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 ||
        bus.mem_wdata !== '0 || buf_count !== '0 || cpu_rdata !== '0 || cpu_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h count=%0d rdata=%h stall=%b, required all 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, buf_count, cpu_rdata, cpu_stall);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    int st;
    set_mode(0);
    for (int i = 0; i < 3; i++) cpu_op(1'b0, 1'b1, 32'h10 + 32'(4 * i), $urandom, rd, st);
    @(negedge clk);
    n_checks++;
    if (bus.mem_req !== 1'b1 || buf_count !== CW'(3)) begin
      n_errors++;
      $display("FAIL midwrite_setup: req=%b count=%0d, required 1/3", bus.mem_req, buf_count);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b0 || buf_count !== '0) begin
      n_errors++;
      $display("FAIL async_reset: req=%b count=%0d, required 0/0 without a clock edge", bus.mem_req, buf_count);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.mem_req !== 1'b0 || buf_count !== '0) begin
        n_errors++;
        $display("FAIL post_reset_idle[%0d]: req=%b count=%0d, required 0/0", i, bus.mem_req, buf_count);
      end
    end
    exp_wr.delete();
    txn_log.delete();
    ref_arch = mem_arr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_forward();
    logic [31:0] rd;
    int st;
    set_mode(0);
    saw_read = 0;
    cpu_op(1'b0, 1'b1, 32'h100, 32'hAAAA_0001, rd, st);
    cpu_op(1'b0, 1'b1, 32'h100, 32'hBBBB_0002, rd, st);
    cpu_op(1'b1, 1'b0, 32'h102, 32'h0, rd, st);
    n_checks++;
    if (rd !== 32'hBBBB_0002 || st != 0) begin
      n_errors++;
      $display("FAIL forward_youngest: rdata=%h stalls=%0d, required BBBB0002/0", rd, st);
    end
    n_checks++;
    if (saw_read !== 1'b0) begin
      n_errors++;
      $display("FAIL forward_no_read: a memory read was issued, required none");
    end
    set_mode(1);
    wait_drain();
    check_writes("forward");
  endtask

  task automatic test_full();
    logic [31:0] rd;
    int st;
    bit done = 0;
    set_mode(0);
    for (int i = 0; i < 4; i++) cpu_op(1'b0, 1'b1, 32'h40 + 32'(4 * i), $urandom, rd, st);
    @(negedge clk);
    n_checks++;
    if (buf_count !== CW'(4)) begin
      n_errors++;
      $display("FAIL full_count: buf_count=%0d, required 4", buf_count);
    end
    cpu_memwrite = 1'b1;
    cpu_addr     = 32'h50;
    cpu_wdata    = 32'hF1F7_0005;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (cpu_stall !== 1'b1) begin
        n_errors++;
        $display("FAIL full_stall[%0d]: cpu_stall=%b, required 1", i, cpu_stall);
      end
    end
    set_mode(3);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        done = 1;
        break;
      end
    end
    n_checks++;
    if (!done || buf_count !== CW'(3)) begin
      n_errors++;
      $display("FAIL full_release: released=%0d buf_count=%0d, required 1/3", done, buf_count);
    end
    @(posedge clk);
    #1;
    exp_wr.push_back({1'b1, 32'h50, 32'hF1F7_0005});
    ref_arch[30'h14] = 32'hF1F7_0005;
    cpu_memwrite = 1'b0;
    @(negedge clk);
    n_checks++;
    if (buf_count !== CW'(4)) begin
      n_errors++;
      $display("FAIL full_refill: buf_count=%0d, required 4", buf_count);
    end
    set_mode(1);
    wait_drain();
    check_writes("full");
  endtask

  task automatic test_load_miss();
    logic [31:0] rd;
    int st;
    txn_t t;
    mem_arr[30'h80]  = 32'h1234_5678;
    ref_arch[30'h80] = 32'h1234_5678;
    fixed_delay = 0;
    set_mode(2);
    cpu_op(1'b1, 1'b0, 32'h200, 32'h0, rd, st);
    n_checks++;
    if (rd !== 32'h1234_5678 || st != 2) begin
      n_errors++;
      $display("FAIL miss_latency0: rdata=%h stalls=%0d, required 12345678/2", rd, st);
    end
    t = txn_log[$];
    n_checks++;
    if (txn_log.size() != 1 || t.we !== 1'b0 || t.addr !== 32'h200) begin
      n_errors++;
      $display("FAIL miss_bus0: txns=%0d we=%b addr=%h, required 1/0/00000200", txn_log.size(), t.we, t.addr);
    end
    txn_log.delete();
    fixed_delay = 2;
    set_mode(2);
    cpu_op(1'b1, 1'b0, 32'h20E, 32'h0, rd, st);
    t = txn_log[$];
    n_checks++;
    if (rd !== arch_get(30'h83) || st != 4 || t.addr !== 32'h20C || t.we !== 1'b0) begin
      n_errors++;
      $display("FAIL miss_latency2: rdata=%h stalls=%0d addr=%h, required %h/4/0000020C",
               rd, st, t.addr, arch_get(30'h83));
    end
    txn_log.delete();
  endtask

  task automatic test_read_priority();
    logic [31:0] rd;
    int st;
    txn_t exp [$];
    set_mode(0);
    cpu_op(1'b0, 1'b1, 32'h500, 32'h0000_0A0A, rd, st);
    cpu_op(1'b0, 1'b1, 32'h504, 32'h0000_0B0B, rd, st);
    cpu_op(1'b0, 1'b1, 32'h508, 32'h0000_0C0C, rd, st);
    exp.push_back({1'b1, 32'h500, 32'h0000_0A0A});
    exp.push_back({1'b0, 32'h600, 32'h0});
    exp.push_back({1'b1, 32'h504, 32'h0000_0B0B});
    exp.push_back({1'b1, 32'h508, 32'h0000_0C0C});
    fixed_delay = 0;
    fork
      cpu_op(1'b1, 1'b0, 32'h600, 32'h0, rd, st);
      begin
        repeat (3) @(negedge clk);
        set_mode(2);
      end
    join
    n_checks++;
    if (rd !== arch_get(30'h180)) begin
      n_errors++;
      $display("FAIL prio_rdata: rdata=%h, required %h", rd, arch_get(30'h180));
    end
    wait_drain();
    n_checks++;
    if (txn_log.size() != exp.size()) begin
      n_errors++;
      $display("FAIL prio_txn_count: got %0d, required %0d", txn_log.size(), exp.size());
    end
    for (int i = 0; i < txn_log.size() && i < exp.size(); i++) begin
      n_checks++;
      if (txn_log[i] !== exp[i]) begin
        n_errors++;
        $display("FAIL prio_txn[%0d]: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h", i,
                 txn_log[i].we, txn_log[i].addr, txn_log[i].data, exp[i].we, exp[i].addr, exp[i].data);
      end
    end
    txn_log.delete();
    exp_wr.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int st;
    set_mode(1);
    for (int i = 0; i < 12; i++)
      cpu_op(1'b0, 1'b1, 32'h800 + 32'($urandom_range(0, 15) * 4), $urandom, rd, st);
    wait_drain();
    check_writes("wrap");
    n_checks++;
    if (buf_count !== '0) begin
      n_errors++;
      $display("FAIL wrap_count: buf_count=%0d, required 0", buf_count);
    end
  endtask

  task automatic test_random_mix();
    logic [31:0] rd, a;
    int st;
    set_mode(1);
    for (int i = 0; i < 80; i++) begin
      a = 32'h900 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        cpu_op(1'b0, 1'b1, a, $urandom, rd, st);
      end else begin
        cpu_op(1'b1, 1'b0, a, 32'h0, rd, st);
        n_checks++;
        if (rd !== arch_get(a[31:2])) begin
          n_errors++;
          $display("FAIL mix_load[%0d] addr=%h: rdata=%h, required %h", i, a, rd, arch_get(a[31:2]));
        end
      end
    end
    wait_drain();
    check_writes("mix");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    cpu_memread  = 1'b0;
    cpu_memwrite = 1'b0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset_mid_write();
    test_forward();
    test_full();
    test_load_miss();
    test_read_priority();
    test_back_to_back();
    test_random_mix();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
